// File: rtl/downcounter_4_bit.sv
// Synchronous 4-bit binary down counter with parallel load, optional auto-reload and
// borrow output for cascading. All state changes on the falling edge of clk.
module downcounter_4_bit (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       load,
  input  logic       auto_reload,
  input  logic [3:0] d,
  output logic       Q0,
  output logic       Q1,
  output logic       Q2,
  output logic       Q3,
  output logic       Q0_bar,
  output logic       Q1_bar,
  output logic       Q2_bar,
  output logic       Q3_bar,
  output logic       borrow,
  output logic       zero
);

  logic [3:0] count;
  logic [3:0] count_next;
  logic [3:0] toggle;
  logic       at_zero;

  assign at_zero = (count == 4'h0);

  // T flip-flop toggle terms: bit k flips when every lower bit is already 0.
  always_comb begin
    toggle[0] = en;
    toggle[1] = en & ~count[0];
    toggle[2] = en & ~count[0] & ~count[1];
    toggle[3] = en & ~count[0] & ~count[1] & ~count[2];
  end

  // Clear, load and reload override the toggle path; plain toggling from 0 already wraps to 15.
  always_comb begin
    count_next = count ^ toggle;
    if (clr) begin
      count_next = 4'h0;
    end else if (load) begin
      count_next = d;
    end else if (en && at_zero && auto_reload) begin
      count_next = d;
    end
  end

  always_ff @(negedge clk) begin
    count <= count_next;
  end

  always_comb begin
    Q0     = count[0];
    Q1     = count[1];
    Q2     = count[2];
    Q3     = count[3];
    Q0_bar = ~count[0];
    Q1_bar = ~count[1];
    Q2_bar = ~count[2];
    Q3_bar = ~count[3];
    zero   = at_zero;
    borrow = en & at_zero;
  end

endmodule

// File: tb/tb_downcounter_4_bit.sv
// Bench for downcounter_4_bit: directed vectors, an arithmetic reference model checked every
// cycle, and a two-stage cascade checked against an 8-bit modulo-256 count.
module tb_downcounter_4_bit;

  logic       clk = 1'b0;
  logic       clr, en, load, auto_reload;
  logic [3:0] d;
  logic       q0, q1, q2, q3, qb0, qb1, qb2, qb3, borrow, zero;

  logic       casc_clr, casc_en;
  logic       lq0, lq1, lq2, lq3, lqb0, lqb1, lqb2, lqb3, lborrow, lzero;
  logic       hq0, hq1, hq2, hq3, hqb0, hqb1, hqb2, hqb3, hborrow, hzero;

  int vectors = 0;
  int miscompares = 0;

  int mq = 0;
  bit mvalid = 1'b0;
  int c8 = 0;
  bit cvalid = 1'b0;

  logic [3:0] dq, dqb;
  logic [7:0] cq;
  assign dq  = {q3, q2, q1, q0};
  assign dqb = {qb3, qb2, qb1, qb0};
  assign cq  = {hq3, hq2, hq1, hq0, lq3, lq2, lq1, lq0};

  always #5 clk = ~clk;

  downcounter_4_bit dut (
    .clk(clk), .clr(clr), .en(en), .load(load), .auto_reload(auto_reload), .d(d),
    .Q0(q0), .Q1(q1), .Q2(q2), .Q3(q3),
    .Q0_bar(qb0), .Q1_bar(qb1), .Q2_bar(qb2), .Q3_bar(qb3),
    .borrow(borrow), .zero(zero)
  );

  downcounter_4_bit u_lo (
    .clk(clk), .clr(casc_clr), .en(casc_en), .load(1'b0), .auto_reload(1'b0), .d(4'h0),
    .Q0(lq0), .Q1(lq1), .Q2(lq2), .Q3(lq3),
    .Q0_bar(lqb0), .Q1_bar(lqb1), .Q2_bar(lqb2), .Q3_bar(lqb3),
    .borrow(lborrow), .zero(lzero)
  );

  downcounter_4_bit u_hi (
    .clk(clk), .clr(casc_clr), .en(lborrow), .load(1'b0), .auto_reload(1'b0), .d(4'h0),
    .Q0(hq0), .Q1(hq1), .Q2(hq2), .Q3(hq3),
    .Q0_bar(hqb0), .Q1_bar(hqb1), .Q2_bar(hqb2), .Q3_bar(hqb3),
    .borrow(hborrow), .zero(hzero)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the count as a plain integer, updated by the operating rules.
  always @(negedge clk) begin
    if (clr) begin
      mq = 0;
      mvalid = 1'b1;
    end else if (load) begin
      mq = int'(d);
    end else if (en) begin
      if (mq == 0) mq = auto_reload ? int'(d) : 15;
      else         mq = mq - 1;
    end
    if (casc_clr) begin
      c8 = 0;
      cvalid = 1'b1;
    end else if (casc_en) begin
      c8 = (c8 + 255) % 256;
    end
  end

  always @(posedge clk) begin
    if (mvalid) begin
      chk("cyc_q", 32'(dq), 32'(mq));
      chk("cyc_qbar", 32'(dqb), 32'(15 - mq));
      chk("cyc_zero", 32'(zero), 32'(mq == 0));
      chk("cyc_borrow", 32'(borrow), 32'(en && (mq == 0)));
    end
    if (cvalid) chk("cyc_cascade", 32'(cq), 32'(c8));
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int ar_exp [7] = '{4, 3, 2, 1, 0, 5, 4};

  initial begin
    clr = 1'b1; en = 1'b1; load = 1'b0; auto_reload = 1'b0; d = 4'h0;
    casc_clr = 1'b1; casc_en = 1'b1;

    // Reset for two edges with en high
    edges(2);
    chk("rst_q", 32'(dq), 32'h0);
    chk("rst_qbar", 32'(dqb), 32'hF);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_borrow", 32'(borrow), 32'h1);

    // Free-run 17 edges from 0: 15, 14, ..., 0, 15
    clr = 1'b0;
    edges(1);
    chk("free_first_q", 32'(dq), 32'hF);
    chk("free_first_zero", 32'(zero), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      edges(1);
      chk("free_q", 32'(dq), 32'((31 - i) % 16));
      if (i == 15) chk("free_borrow_at_0", 32'(borrow), 32'h1);
      if (i == 14) chk("free_borrow_at_1", 32'(borrow), 32'h0);
    end

    // Load 9, hold 3 edges, then count 8, 7
    load = 1'b1; d = 4'h9;
    edges(1);
    chk("load_q", 32'(dq), 32'h9);
    load = 1'b0; en = 1'b0;
    edges(3);
    chk("hold_q", 32'(dq), 32'h9);
    chk("hold_borrow", 32'(borrow), 32'h0);
    en = 1'b1;
    edges(1);
    chk("cnt_8", 32'(dq), 32'h8);
    edges(1);
    chk("cnt_7", 32'(dq), 32'h7);

    // Auto-reload with d = 5: period 6
    auto_reload = 1'b1; load = 1'b1; d = 4'h5;
    edges(1);
    chk("ar_load", 32'(dq), 32'h5);
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      edges(1);
      chk("ar_seq", 32'(dq), 32'(ar_exp[i]));
    end

    // Auto-reload with d = 0 parks at zero, borrow stays high
    load = 1'b1; d = 4'h0;
    edges(1);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      chk("ar0_q", 32'(dq), 32'h0);
      chk("ar0_borrow", 32'(borrow), 32'h1);
    end

    // Priority: clr beats load; load beats count at zero
    auto_reload = 1'b0; load = 1'b1; d = 4'h6;
    edges(1);
    chk("pri_pre_q", 32'(dq), 32'h6);
    clr = 1'b1; d = 4'hF;
    edges(1);
    chk("pri_clr_load", 32'(dq), 32'h0);
    clr = 1'b0; d = 4'h3;
    edges(1);
    chk("pri_load_at_0", 32'(dq), 32'h3);
    load = 1'b0;
    edges(1);
    chk("pri_after_load", 32'(dq), 32'h2);

    // Mid-count clear, then reload from d on the next enabled edge
    clr = 1'b1;
    edges(1);
    chk("mid_clr", 32'(dq), 32'h0);
    clr = 1'b0; auto_reload = 1'b1; d = 4'h7;
    edges(1);
    chk("mid_reload", 32'(dq), 32'h7);
    auto_reload = 1'b0;

    // Cascade: 8-bit down count 0x00, 0xFF, 0xFE, ..., 0xFF after 257 edges
    chk("casc_rst", 32'(cq), 32'h00);
    casc_clr = 1'b0;
    edges(1);
    chk("casc_ff", 32'(cq), 32'hFF);
    edges(1);
    chk("casc_fe", 32'(cq), 32'hFE);
    edges(254);
    chk("casc_00", 32'(cq), 32'h00);
    edges(1);
    chk("casc_257", 32'(cq), 32'hFF);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
